axil_regbus_bridge: RTL and testbench
=====================================

# axil_regbus_bridge

AXI4-Lite responder that converts PS/host register accesses into REG_BUS transactions for the fabric register file. It terminates the AXI4Lite slave side and drives the REG_BUS master side, with single-outstanding writes and reads and a read-response timeout. It sits between the PS AXI interconnect and the register block that drives the RFSOC_REG control/status interface.

## Interface
- ADDR_WIDTH, 32, address width for both AXI4Lite and REG_BUS.
- DATA_WIDTH, 32, data width for both buses. Must be 32 or 64.
- RD_TIMEOUT, 255, number of cycles to wait for rvld before an error response. Must be ≥1.

Ports:
- clk  in  1  single clock for all logic.
- rst_n  in  1  asynchronous active-low reset.
- s_axil  AXI4Lite.slave  ADDR_WIDTH/DATA_WIDTH  host register access; awprot/arprot ignored.
- m_reg  REG_BUS.master  ADDR_WIDTH/DATA_WIDTH  register-file access.

## Operation
- Write and read paths are independent FSMs and may be active in the same cycle.
- **Write FSM: W_IDLE → W_ISSUE → W_RESP → W_IDLE.**
  - W_IDLE: awready=!aw_held and wready=!w_held. AW and W may arrive in either order or together; each is captured into a holding register on handshake. When both are held (including same-cycle capture), go to W_ISSUE on the next cycle.
  - W_ISSUE: wren=1 for exactly one cycle, with waddr=awaddr, wdata, and wstrb passed through unmodified. wstrb=0 still pulses wren. Go to W_RESP.
  - W_RESP: bvalid=1, bresp=2'b00. Hold until bready. Then clear the holding flags and return to W_IDLE.
  - awready and wready are 0 outside W_IDLE.
- **Read FSM: R_IDLE → R_ISSUE → R_WAIT → R_RESP → R_IDLE.**
  - R_IDLE: arready=1. On arvalid, capture araddr and go to R_ISSUE.
  - R_ISSUE: rden=1 for one cycle with raddr=captured address. Clear the timeout counter. Go to R_WAIT.
  - R_WAIT: each cycle, if rvld=1, register rdata and set rresp=2'b00, then go to R_RESP. Otherwise increment the counter. When the counter reaches RD_TIMEOUT without rvld, set rdata=0 and rresp=2'b10 (SLVERR), then go to R_RESP. If rvld arrives on the final wait cycle, it wins: OKAY with data.
  - R_RESP: rvalid=1 with rdata/rresp held stable until rready. Then go to R_IDLE.
  - rvld outside R_WAIT is ignored, including rvld in the same cycle as the rden pulse.
- **Counter:** width is $clog2(RD_TIMEOUT+1). It saturates and never wraps.
- **Reset mid-transaction:** all in-flight state is discarded and no response is issued. Neither wren nor rden fires after reset deassertion until a new AXI request arrives.

## Timing
- **Reset values:** awready=0, wready=0, arready=0, bvalid=0, bresp=0, rvalid=0, rresp=0, rdata=0, wren=0, rden=0, waddr/wdata/wstrb/raddr=0. The ready signals rise on the first clk edge after rst_n deasserts.
- All outputs are registered; there is no combinational path from AXI inputs to outputs.
- **Write latency:** AW+W handshake at cycle 0 → wren at cycle 1 → bvalid at cycle 2. Next awready is no earlier than the cycle after B handshake.
- **Read latency:** AR handshake at cycle 0 → rden at cycle 1 → earliest rvld at cycle 2 → rvalid at cycle 3.
- **Read timeout:** rden at cycle 1 with no rvld → rvalid with SLVERR at cycle RD_TIMEOUT+2.
- **Throughput:** one outstanding write and one outstanding read. Back-to-back writes take 3 cycles each minimum, and back-to-back reads take 4 cycles each minimum, when bready/rready are held high.

## Test plan
- AW and W same cycle: addr 0x0000_0010, data 0xA5A5_0001, strb 0xF → one wren pulse at cycle 1 with matching waddr/wdata/wstrb; bvalid at cycle 2 with bresp=0.
- W arrives 3 cycles before AW (addr 0x24): wready drops after capture → wren fires the cycle after the AW handshake; exactly one wren pulse total.
- Read 0x0000_0008, register model returns rvld 2 cycles after rden with data 0x1234_5678 → rvalid with rdata=0x1234_5678 and rresp=0. rready is held low for 4 cycles and rdata stays stable throughout.
- Read with no rvld and RD_TIMEOUT=8 → rvalid at cycle 10 with rresp=2'b10 and rdata=0. A stray rvld afterwards is ignored.
- Concurrent write and read issued in the same cycle → wren at cycle 1 and rden at cycle 1; both responses complete correctly.
- Reset asserted in R_WAIT and in W_RESP → all outputs return to reset values asynchronously. No rvalid, bvalid, wren, or rden after release until a new request; the next read completes normally.

Source files
------------

// File: rtl/axil_regbus_bridge.sv
// AXI4-Lite responder that turns host register accesses into REG_BUS transactions.
// Write and read paths are independent single-outstanding FSMs; reads time out with SLVERR.
module axil_regbus_bridge #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned RD_TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      rst_n,
  // AXI4-Lite slave: write address
  input  logic [ADDR_WIDTH-1:0]     s_axil_awaddr_i,
  input  logic [2:0]                s_axil_awprot_i,
  input  logic                      s_axil_awvalid_i,
  output logic                      s_axil_awready_o,
  // AXI4-Lite slave: write data
  input  logic [DATA_WIDTH-1:0]     s_axil_wdata_i,
  input  logic [DATA_WIDTH/8-1:0]   s_axil_wstrb_i,
  input  logic                      s_axil_wvalid_i,
  output logic                      s_axil_wready_o,
  // AXI4-Lite slave: write response
  output logic [1:0]                s_axil_bresp_o,
  output logic                      s_axil_bvalid_o,
  input  logic                      s_axil_bready_i,
  // AXI4-Lite slave: read address
  input  logic [ADDR_WIDTH-1:0]     s_axil_araddr_i,
  input  logic [2:0]                s_axil_arprot_i,
  input  logic                      s_axil_arvalid_i,
  output logic                      s_axil_arready_o,
  // AXI4-Lite slave: read data
  output logic [DATA_WIDTH-1:0]     s_axil_rdata_o,
  output logic [1:0]                s_axil_rresp_o,
  output logic                      s_axil_rvalid_o,
  input  logic                      s_axil_rready_i,
  // REG_BUS master
  output logic                      m_reg_wren_o,
  output logic [ADDR_WIDTH-1:0]     m_reg_waddr_o,
  output logic [DATA_WIDTH-1:0]     m_reg_wdata_o,
  output logic [DATA_WIDTH/8-1:0]   m_reg_wstrb_o,
  output logic                      m_reg_rden_o,
  output logic [ADDR_WIDTH-1:0]     m_reg_raddr_o,
  input  logic [DATA_WIDTH-1:0]     m_reg_rdata_i,
  input  logic                      m_reg_rvld_i
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned CNT_WIDTH  = $clog2(RD_TIMEOUT + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_LIMIT = CNT_WIDTH'(RD_TIMEOUT);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_ISSUE, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_WAIT, R_RESP} r_state_e;

  // Protection attributes carry no meaning for the register file.
  logic prot_unused;
  assign prot_unused = ^{s_axil_awprot_i, s_axil_arprot_i};

  // ---------------------------------------------------------------- write path
  w_state_e                w_state_q;
  logic                    aw_held_q, w_held_q;
  logic                    aw_held_d, w_held_d;
  logic                    aw_hs, w_hs;
  logic                    awready_q, wready_q, bvalid_q, wren_q;
  logic [ADDR_WIDTH-1:0]   waddr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [STRB_WIDTH-1:0]   wstrb_q;

  assign aw_hs     = s_axil_awvalid_i & awready_q;
  assign w_hs      = s_axil_wvalid_i & wready_q;
  assign aw_held_d = aw_held_q | aw_hs;
  assign w_held_d  = w_held_q | w_hs;

  // The REG_BUS write address/data registers double as the AW/W holding registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state_q <= W_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      wren_q    <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      wren_q <= 1'b0;
      case (w_state_q)
        W_IDLE: begin
          if (aw_hs) begin
            aw_held_q <= 1'b1;
            waddr_q   <= s_axil_awaddr_i;
          end
          if (w_hs) begin
            w_held_q <= 1'b1;
            wdata_q  <= s_axil_wdata_i;
            wstrb_q  <= s_axil_wstrb_i;
          end
          if (aw_held_d && w_held_d) begin
            w_state_q <= W_ISSUE;
            wren_q    <= 1'b1;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
          end else begin
            awready_q <= !aw_held_d;
            wready_q  <= !w_held_d;
          end
        end
        W_ISSUE: begin
          w_state_q <= W_RESP;
          bvalid_q  <= 1'b1;
        end
        W_RESP: begin
          if (s_axil_bready_i) begin
            w_state_q <= W_IDLE;
            bvalid_q  <= 1'b0;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
          end
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  // ----------------------------------------------------------------- read path
  r_state_e                r_state_q;
  logic                    arready_q, rvalid_q, rden_q;
  logic [1:0]              rresp_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic [ADDR_WIDTH-1:0]   raddr_q;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;

  // Saturating wait counter; it never wraps even if left running.
  assign cnt_d = (cnt_q == CNT_LIMIT) ? cnt_q : cnt_q + CNT_WIDTH'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rden_q    <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
      raddr_q   <= '0;
      cnt_q     <= '0;
    end else begin
      rden_q <= 1'b0;
      case (r_state_q)
        R_IDLE: begin
          if (s_axil_arvalid_i && arready_q) begin
            r_state_q <= R_ISSUE;
            raddr_q   <= s_axil_araddr_i;
            arready_q <= 1'b0;
            rden_q    <= 1'b1;
          end else begin
            arready_q <= 1'b1;
          end
        end
        R_ISSUE: begin
          r_state_q <= R_WAIT;
          cnt_q     <= '0;
        end
        R_WAIT: begin
          // A response on the last wait cycle still beats the timeout.
          if (m_reg_rvld_i) begin
            r_state_q <= R_RESP;
            rdata_q   <= m_reg_rdata_i;
            rresp_q   <= RESP_OKAY;
            rvalid_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_d;
            if (cnt_d == CNT_LIMIT) begin
              r_state_q <= R_RESP;
              rdata_q   <= '0;
              rresp_q   <= RESP_SLVERR;
              rvalid_q  <= 1'b1;
            end
          end
        end
        R_RESP: begin
          if (s_axil_rready_i) begin
            r_state_q <= R_IDLE;
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
          end
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  // ------------------------------------------------------------------- outputs
  assign s_axil_awready_o = awready_q;
  assign s_axil_wready_o  = wready_q;
  assign s_axil_bresp_o   = RESP_OKAY;
  assign s_axil_bvalid_o  = bvalid_q;
  assign s_axil_arready_o = arready_q;
  assign s_axil_rdata_o   = rdata_q;
  assign s_axil_rresp_o   = rresp_q;
  assign s_axil_rvalid_o  = rvalid_q;
  assign m_reg_wren_o     = wren_q;
  assign m_reg_waddr_o    = waddr_q;
  assign m_reg_wdata_o    = wdata_q;
  assign m_reg_wstrb_o    = wstrb_q;
  assign m_reg_rden_o     = rden_q;
  assign m_reg_raddr_o    = raddr_q;

endmodule

// File: tb/tb_axil_regbus_bridge.sv
// Self-checking bench for axil_regbus_bridge: directed vector table, reset sequences,
// and randomized concurrent traffic checked against cycle-offset rules.
module tb_axil_regbus_bridge;

  localparam int T     = 8;
  localparam int NEVER = 99;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] awaddr, wdata, araddr, rdata_o, waddr_o, wdata_o, raddr_o, reg_rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb, wstrb_o;
  logic [1:0]  bresp, rresp;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic        wren, rden, rvld;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;

  axil_regbus_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RD_TIMEOUT(T)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axil_awaddr_i(awaddr), .s_axil_awprot_i(awprot), .s_axil_awvalid_i(awvalid),
    .s_axil_awready_o(awready),
    .s_axil_wdata_i(wdata), .s_axil_wstrb_i(wstrb), .s_axil_wvalid_i(wvalid),
    .s_axil_wready_o(wready),
    .s_axil_bresp_o(bresp), .s_axil_bvalid_o(bvalid), .s_axil_bready_i(bready),
    .s_axil_araddr_i(araddr), .s_axil_arprot_i(arprot), .s_axil_arvalid_i(arvalid),
    .s_axil_arready_o(arready),
    .s_axil_rdata_o(rdata_o), .s_axil_rresp_o(rresp), .s_axil_rvalid_o(rvalid),
    .s_axil_rready_i(rready),
    .m_reg_wren_o(wren), .m_reg_waddr_o(waddr_o), .m_reg_wdata_o(wdata_o),
    .m_reg_wstrb_o(wstrb_o), .m_reg_rden_o(rden), .m_reg_raddr_o(raddr_o),
    .m_reg_rdata_i(reg_rdata), .m_reg_rvld_i(rvld)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          do_wr;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          awd, wd, bd, exp_wren, exp_b;
    bit          do_rd;
    logic [31:0] raddr;
    int          ard, rsp_d;
    logic [31:0] rsp_data;
    int          rrd, exp_rv;
    logic [1:0]  exp_rresp;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t tbl [12];

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0h want %0h", name, cyc, act, exp);
    end
  endtask

  task automatic check_reset(input string name);
    check(name, {awready, wready, arready, bvalid, bresp, rvalid, rresp, rdata_o, wren, rden,
                 waddr_o, wdata_o, wstrb_o, raddr_o}, '0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference rules: write issues one cycle after the later of AW/W, responds one after that.
  function automatic int wr_wren_off(input int awd, input int wd);
    return ((awd > wd) ? awd : wd) + 1;
  endfunction

  // A read response counts only if it lands in one of the T cycles after the rden cycle.
  function automatic bit rd_ok(input int d);
    return (d >= 1) && (d <= T);
  endfunction

  function automatic int rd_rv_off(input int ard, input int d);
    return ard + 1 + (rd_ok(d) ? d + 1 : T + 1);
  endfunction

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int awd, input int wd, input int bd,
                          input int exp_wren, input int exp_b);
    int start, n_end;
    start = cyc;
    n_end = start + exp_b + bd;
    for (int n = start; n <= n_end; n++) begin
      awvalid = (n == start + awd);
      awaddr  = (n == start + awd) ? addr : $urandom;
      awprot  = 3'($urandom);
      wvalid  = (n == start + wd);
      wdata   = (n == start + wd) ? data : $urandom;
      wstrb   = (n == start + wd) ? strb : 4'($urandom);
      bready  = (n == n_end) ? 1'b1 : (n < start + exp_b) ? 1'($urandom) : 1'b0;
      @(negedge clk);
      check("wr_ctrl", {awready, wready, wren, bvalid},
            {n <= start + awd, n <= start + wd, n == start + exp_wren, n >= start + exp_b});
      if (n == start + exp_wren) check("wr_bus", {waddr_o, wdata_o, wstrb_o}, {addr, data, strb});
      if (n >= start + exp_b) check("wr_bresp", bresp, 2'b00);
      if (n != n_end) tick();
    end
    tick();
    awvalid = 1'b0;
    wvalid  = 1'b0;
    bready  = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] addr, input int ard, input int rsp_d,
                         input logic [31:0] rsp_data, input int rrd, input int exp_rv,
                         input logic [1:0] exp_rresp, input logic [31:0] exp_rdata);
    int start, rden_c, rv, n_end;
    start  = cyc;
    rden_c = start + ard + 1;
    rv     = start + exp_rv;
    n_end  = rv + rrd;
    for (int n = start; n <= n_end; n++) begin
      arvalid   = (n == start + ard);
      araddr    = (n == start + ard) ? addr : $urandom;
      arprot    = 3'($urandom);
      // Stray rvld only where the bridge must ignore it.
      rvld      = (n == rden_c + rsp_d) || (((n <= rden_c) || (n >= rv)) && ($urandom_range(0, 3) == 0));
      reg_rdata = (n == rden_c + rsp_d) ? rsp_data : $urandom;
      rready    = (n == n_end) ? 1'b1 : (n < rv) ? 1'($urandom) : 1'b0;
      @(negedge clk);
      check("rd_ctrl", {arready, rden, rvalid}, {n <= start + ard, n == rden_c, n >= rv});
      if (n == rden_c) check("rd_raddr", raddr_o, addr);
      if (n >= rv) check("rd_data", {rresp, rdata_o}, {exp_rresp, exp_rdata});
      if (n != n_end) tick();
    end
    tick();
    arvalid = 1'b0;
    rvld    = 1'b0;
    rready  = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  int  r_awd, r_wd, r_bd, r_ard, r_d, r_rrd, r_wo;
  bit  r_dowr, r_dord;
  logic [31:0] r_wa, r_wdat, r_ra, r_rdat;
  logic [3:0]  r_strb;

  initial begin
    //              wr  waddr        wdata          strb  awd wd bd wren b   rd  raddr     ard d      rsp_data       rrd rv resp   rdata
    tbl[0]  = '{1'b1, 32'h10, 32'hA5A5_0001, 4'hF, 0, 0, 0, 1, 2, 1'b0, 32'h0,  0, 0,     32'h0,         0, 0,  2'b00, 32'h0};
    tbl[1]  = '{1'b1, 32'h24, 32'hDEAD_0024, 4'hF, 3, 0, 0, 4, 5, 1'b0, 32'h0,  0, 0,     32'h0,         0, 0,  2'b00, 32'h0};
    tbl[2]  = '{1'b1, 32'h30, 32'h00C0_FFEE, 4'h5, 0, 2, 2, 3, 4, 1'b0, 32'h0,  0, 0,     32'h0,         0, 0,  2'b00, 32'h0};
    tbl[3]  = '{1'b1, 32'h3C, 32'h1111_2222, 4'h0, 0, 0, 1, 1, 2, 1'b0, 32'h0,  0, 0,     32'h0,         0, 0,  2'b00, 32'h0};
    tbl[4]  = '{1'b0, 32'h0,  32'h0,         4'h0, 0, 0, 0, 0, 0, 1'b1, 32'h08, 0, 2,     32'h1234_5678, 4, 4,  2'b00, 32'h1234_5678};
    tbl[5]  = '{1'b0, 32'h0,  32'h0,         4'h0, 0, 0, 0, 0, 0, 1'b1, 32'h40, 0, NEVER, 32'hFFFF_FFFF, 1, 10, 2'b10, 32'h0};
    tbl[6]  = '{1'b0, 32'h0,  32'h0,         4'h0, 0, 0, 0, 0, 0, 1'b1, 32'h44, 0, 8,     32'hCAFE_F00D, 0, 10, 2'b00, 32'hCAFE_F00D};
    tbl[7]  = '{1'b0, 32'h0,  32'h0,         4'h0, 0, 0, 0, 0, 0, 1'b1, 32'h48, 0, 9,     32'hBAD0_BAD0, 0, 10, 2'b10, 32'h0};
    tbl[8]  = '{1'b0, 32'h0,  32'h0,         4'h0, 0, 0, 0, 0, 0, 1'b1, 32'h4C, 0, 0,     32'h0BAD_F00D, 0, 10, 2'b10, 32'h0};
    tbl[9]  = '{1'b0, 32'h0,  32'h0,         4'h0, 0, 0, 0, 0, 0, 1'b1, 32'h50, 0, 1,     32'h55AA_55AA, 0, 3,  2'b00, 32'h55AA_55AA};
    tbl[10] = '{1'b1, 32'h60, 32'h600D_600D, 4'hF, 0, 0, 0, 1, 2, 1'b1, 32'h64, 0, 1,     32'h6464_6464, 0, 3,  2'b00, 32'h6464_6464};
    tbl[11] = '{1'b1, 32'h68, 32'h6868_0000, 4'hC, 1, 2, 1, 3, 4, 1'b1, 32'h6C, 2, 3,     32'h6C6C_0003, 2, 7,  2'b00, 32'h6C6C_0003};

    awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0; rvld = 1'b0; reg_rdata = '0;

    // Reset values, then readies rise on the first edge after release.
    repeat (2) @(negedge clk);
    check_reset("reset_values");
    check("ready_in_reset", {awready, wready, arready}, 3'b000);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_release", {awready, wready, arready}, 3'b111);
    tick();

    for (int i = 0; i < 12; i++) begin
      fork
        begin
          if (tbl[i].do_wr)
            do_write(tbl[i].waddr, tbl[i].wdata, tbl[i].wstrb, tbl[i].awd, tbl[i].wd, tbl[i].bd,
                     tbl[i].exp_wren, tbl[i].exp_b);
        end
        begin
          if (tbl[i].do_rd)
            do_read(tbl[i].raddr, tbl[i].ard, tbl[i].rsp_d, tbl[i].rsp_data, tbl[i].rrd,
                    tbl[i].exp_rv, tbl[i].exp_rresp, tbl[i].exp_rdata);
        end
      join
    end

    // Reset while the write waits in W_RESP and the read waits in R_WAIT.
    awvalid = 1'b1; awaddr = 32'h80; wvalid = 1'b1; wdata = 32'h8080_8080; wstrb = 4'hF;
    arvalid = 1'b1; araddr = 32'h84; bready = 1'b0; rready = 1'b0; rvld = 1'b0;
    @(negedge clk);
    check("rst_seq_hs", {awready, wready, arready}, 3'b111);
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    @(negedge clk);
    check("rst_seq_issue", {wren, rden}, 2'b11);
    tick();
    tick();
    #1 check("rst_seq_pending", {bvalid, rvalid}, 2'b10);
    #1 rst_n = 1'b0;
    #1 check_reset("reset_async");
    repeat (2) @(negedge clk);
    check_reset("reset_held");
    #1 rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      rvld = 1'($urandom); reg_rdata = $urandom; bready = 1'($urandom); rready = 1'($urandom);
      @(negedge clk);
      check("post_reset_quiet", {bvalid, rvalid, wren, rden, awready, wready, arready}, 7'b0000111);
    end
    tick();
    rvld = 1'b0; bready = 1'b0; rready = 1'b0;
    do_read(32'h88, 0, 2, 32'h0F0F_1234, 1, rd_rv_off(0, 2), 2'b00, 32'h0F0F_1234);
    do_write(32'h8C, 32'h8C8C_8C8C, 4'hF, 0, 1, 0, wr_wren_off(0, 1), wr_wren_off(0, 1) + 1);

    // Randomized concurrent traffic against the offset rules.
    for (int it = 0; it < 60; it++) begin
      r_dowr = ($urandom_range(0, 3) != 0);
      r_dord = ($urandom_range(0, 3) != 0);
      if (!r_dowr && !r_dord) r_dowr = 1'b1;
      r_awd = $urandom_range(0, 3); r_wd = $urandom_range(0, 3); r_bd = $urandom_range(0, 3);
      r_wa = $urandom; r_wdat = $urandom; r_strb = 4'($urandom);
      r_wo = wr_wren_off(r_awd, r_wd);
      r_ard = $urandom_range(0, 3); r_rrd = $urandom_range(0, 3);
      r_d = $urandom_range(0, T + 3);
      if (r_d == T + 3) r_d = NEVER;
      r_ra = $urandom; r_rdat = $urandom;
      fork
        begin
          if (r_dowr) do_write(r_wa, r_wdat, r_strb, r_awd, r_wd, r_bd, r_wo, r_wo + 1);
        end
        begin
          if (r_dord) do_read(r_ra, r_ard, r_d, r_rdat, r_rrd, rd_rv_off(r_ard, r_d),
                              rd_ok(r_d) ? 2'b00 : 2'b10, rd_ok(r_d) ? r_rdat : 32'h0);
        end
      join
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
